// File: rtl/rega_countdown_pkg.sv
// Shared definitions for the irrigation countdown timer: state encoding,
// digit limit and the prescaler width helper.
package rega_countdown_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int unsigned DIGIT_MAX = 9;

   // Ceiling log2; the prescaler counts 0..PRESCALE-1 so this is its width.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned width;
      width = 0;
      while ((32'd1 << width) < value) begin
         width = width + 1;
      end
      return width;
   endfunction

endpackage

// File: rtl/rega_tick_gen.sv
// Countdown step prescaler.
// Ports:
//   CLK   - system clock
//   RST_N - asynchronous active-low reset
//   EN    - count enable; the count is frozen while low
//   CLR   - synchronous clear to zero (overrides EN)
//   TICK  - high in the enabled cycle where the count is at PRESCALE-1
module rega_tick_gen
   import rega_countdown_pkg::*;
#(
   parameter int unsigned PRESCALE = 50000000
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic EN,
   input  logic CLR,
   output logic TICK
);

   localparam int unsigned W = clog2(PRESCALE);
   localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

   logic [W-1:0] cnt;

   // Wrapping prescale counter.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt <= '0;
      end else if (CLR) begin
         cnt <= '0;
      end else if (EN) begin
         cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
      end
   end

   assign TICK = EN && !CLR && (cnt == LAST);

endmodule

// File: rtl/rega_countdown.sv
// Watering-cycle countdown timer. A start request opens the valve and counts
// a digit down from START_VAL to 0, one step per prescaled tick, with pause,
// abort and early end on the soil-wet sensor.
// Ports:
//   CLK, RST_N           - clock, asynchronous active-low reset
//   START, PAUSE         - start request, pause level
//   ABORT, WET           - cancel without DONE, soil-wet early end
//   C3..C0               - registered digit (binary 0..9) to display decoder
//   VALVE, BUSY, DONE    - registered valve drive and status
module rega_countdown
   import rega_countdown_pkg::*;
#(
   parameter int unsigned PRESCALE  = 50000000,
   parameter int unsigned START_VAL = 9
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic START,
   input  logic PAUSE,
   input  logic ABORT,
   input  logic WET,
   output logic C3,
   output logic C2,
   output logic C1,
   output logic C0,
   output logic VALVE,
   output logic BUSY,
   output logic DONE
);

   if (START_VAL < 1 || START_VAL > DIGIT_MAX) begin : g_bad_start_val
      $error("rega_countdown: START_VAL must be in 1..9");
   end
   if (PRESCALE < 2 || PRESCALE > (32'd1 << 26)) begin : g_bad_prescale
      $error("rega_countdown: PRESCALE must be in 2..2^26");
   end

   localparam logic [3:0] START_DIGIT = 4'(START_VAL);

   state_t     state;
   logic [3:0] count;
   logic       valve_q;
   logic       busy_q;
   logic       done_q;
   logic       tick;
   logic       tick_en;
   logic       tick_clr;

   // The prescaler advances in RUN, and also on the resume edge out of PAUSED,
   // so a pause costs exactly its own length in valve-closed time.
   always_comb begin
      tick_en  = 1'b0;
      tick_clr = 1'b0;
      if ((state == ST_RUN || state == ST_PAUSED) && !ABORT && !WET && !PAUSE) begin
         tick_en = 1'b1;
      end
      if (ABORT || ((state == ST_IDLE || state == ST_DONE) && START)) begin
         tick_clr = 1'b1;
      end
   end

   rega_tick_gen #(
      .PRESCALE (PRESCALE)
   ) u_tick_gen (
      .CLK   (CLK),
      .RST_N (RST_N),
      .EN    (tick_en),
      .CLR   (tick_clr),
      .TICK  (tick)
   );

   // Control FSM with digit and status registers updated on the same edge.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= ST_IDLE;
         count   <= '0;
         valve_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (ABORT) begin
         state   <= ST_IDLE;
         count   <= '0;
         valve_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (START) begin
                  state   <= ST_RUN;
                  count   <= START_DIGIT;
                  valve_q <= 1'b1;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            ST_RUN, ST_PAUSED: begin
               if (WET || (tick && count == 4'd1)) begin
                  state   <= ST_DONE;
                  count   <= '0;
                  valve_q <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else if (PAUSE) begin
                  state   <= ST_PAUSED;
                  valve_q <= 1'b0;
                  busy_q  <= 1'b1;
               end else begin
                  state   <= ST_RUN;
                  valve_q <= 1'b1;
                  busy_q  <= 1'b1;
                  if (tick) begin
                     count <= count - 4'd1;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign {C3, C2, C1, C0} = count;
   assign VALVE = valve_q;
   assign BUSY  = busy_q;
   assign DONE  = done_q;

   a_digit_range: assert property (@(posedge CLK) disable iff (!RST_N) count <= 4'(DIGIT_MAX));

endmodule

// File: tb/tb_rega_countdown.sv
// Directed bench for rega_countdown with PRESCALE=4, START_VAL=3.
module tb_rega_countdown;

   localparam int unsigned PRESCALE  = 4;
   localparam int unsigned START_VAL = 3;
   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   logic CLK = 1'b0;
   logic RST_N, START, PAUSE, ABORT, WET;
   logic C3, C2, C1, C0, VALVE, BUSY, DONE;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string      name;
      logic       start, pause, abort, wet;
      int         n;
      logic [3:0] c;
      logic       valve, busy, done;
   } vec_t;

   vec_t vq[$];

   rega_countdown #(
      .PRESCALE  (PRESCALE),
      .START_VAL (START_VAL)
   ) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .START (START),
      .PAUSE (PAUSE),
      .ABORT (ABORT),
      .WET   (WET),
      .C3    (C3),
      .C2    (C2),
      .C1    (C1),
      .C0    (C0),
      .VALVE (VALVE),
      .BUSY  (BUSY),
      .DONE  (DONE)
   );

   always #5 CLK = ~CLK;

   function automatic vec_t mk(input string nm, input logic s, input logic p, input logic a,
                               input logic w, input int n, input logic [3:0] c,
                               input logic v, input logic b, input logic d);
      vec_t r;
      r.name = nm; r.start = s; r.pause = p; r.abort = a; r.wet = w;
      r.n = n; r.c = c; r.valve = v; r.busy = b; r.done = d;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [3:0] c, input logic v, input logic b,
                      input logic d);
      logic [6:0] got;
      logic [6:0] exp;
      got = {C3, C2, C1, C0, VALVE, BUSY, DONE};
      exp = {c, v, b, d};
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s @%0t: got c=%0d valve/busy/done=%b, required c=%0d valve/busy/done=%b",
                  nm, $time, got[6:3], got[2:0], exp[6:3], exp[2:0]);
      end
   endtask

   initial begin
      int vcnt;
      int guard;

      // Full cycle; START held during RUN must not restart the count.
      vq.push_back(mk("fc_start",   H, L, L, L, 1, 4'd3, H, H, L));
      vq.push_back(mk("fc_c3",      L, L, L, L, 3, 4'd3, H, H, L));
      vq.push_back(mk("fc_c2",      H, L, L, L, 4, 4'd2, H, H, L));
      vq.push_back(mk("fc_c1",      L, L, L, L, 4, 4'd1, H, H, L));
      vq.push_back(mk("fc_done",    L, L, L, L, 3, 4'd0, L, L, H));
      // Pause for 5 cycles two cycles into C=2.
      vq.push_back(mk("pz_start",   H, L, L, L, 1, 4'd3, H, H, L));
      vq.push_back(mk("pz_c3",      L, L, L, L, 3, 4'd3, H, H, L));
      vq.push_back(mk("pz_c2_run",  L, L, L, L, 2, 4'd2, H, H, L));
      vq.push_back(mk("pz_paused",  L, H, L, L, 5, 4'd2, L, H, L));
      vq.push_back(mk("pz_resume",  L, L, L, L, 2, 4'd2, H, H, L));
      vq.push_back(mk("pz_c1",      L, L, L, L, 4, 4'd1, H, H, L));
      vq.push_back(mk("pz_done",    L, L, L, L, 1, 4'd0, L, L, H));
      // WET early end, then restart from DONE.
      vq.push_back(mk("wt_start",   H, L, L, L, 1, 4'd3, H, H, L));
      vq.push_back(mk("wt_c3",      L, L, L, L, 3, 4'd3, H, H, L));
      vq.push_back(mk("wt_c2",      L, L, L, L, 1, 4'd2, H, H, L));
      vq.push_back(mk("wt_wet",     L, L, L, H, 1, 4'd0, L, L, H));
      vq.push_back(mk("wt_hold",    L, L, L, L, 1, 4'd0, L, L, H));
      vq.push_back(mk("wt_restart", H, L, L, L, 1, 4'd3, H, H, L));
      // Abort from PAUSED, then START+ABORT together in IDLE.
      vq.push_back(mk("ab_pause",   L, H, L, L, 2, 4'd3, L, H, L));
      vq.push_back(mk("ab_abort",   L, H, H, L, 1, 4'd0, L, L, L));
      vq.push_back(mk("ab_idle",    L, L, L, L, 3, 4'd0, L, L, L));
      vq.push_back(mk("ab_st_ab",   H, L, H, L, 1, 4'd0, L, L, L));
      vq.push_back(mk("ab_idle2",   L, L, L, L, 1, 4'd0, L, L, L));

      // Reset held with START asserted.
      RST_N = 1'b0; START = 1'b1; PAUSE = 1'b0; ABORT = 1'b0; WET = 1'b0;
      #2 chk("reset_t0", 4'd0, L, L, L);
      repeat (3) begin
         @(negedge CLK);
         chk("reset_hold", 4'd0, L, L, L);
      end
      START = 1'b0;
      RST_N = 1'b1;
      @(negedge CLK);
      chk("post_reset", 4'd0, L, L, L);

      foreach (vq[i]) begin
         START = vq[i].start; PAUSE = vq[i].pause; ABORT = vq[i].abort; WET = vq[i].wet;
         for (int k = 0; k < vq[i].n; k++) begin
            @(negedge CLK);
            chk(vq[i].name, vq[i].c, vq[i].valve, vq[i].busy, vq[i].done);
         end
      end
      START = 1'b0; PAUSE = 1'b0; ABORT = 1'b0; WET = 1'b0;

      // Asynchronous reset between edges while C=1.
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      repeat (8) @(negedge CLK);
      chk("ar_c1", 4'd1, H, H, L);
      #2 RST_N = 1'b0;
      #1 chk("ar_async", 4'd0, L, L, L);
      @(negedge CLK);
      chk("ar_held", 4'd0, L, L, L);
      RST_N = 1'b1;
      @(negedge CLK);
      chk("ar_idle", 4'd0, L, L, L);

      // Full uninterrupted cycle after reset release.
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      vcnt  = VALVE ? 1 : 0;
      guard = 0;
      while (!DONE && guard < 40) begin
         @(negedge CLK);
         if (VALVE) vcnt++;
         guard++;
      end
      chk("ar_rerun_done", 4'd0, L, L, H);
      tests++;
      if (vcnt != 12) begin
         fails++;
         $display("FAIL ar_valve_cycles: got %0d cycles, required 12", vcnt);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rega_countdown.md
Name: rega_countdown

Overview:
- Watering-cycle countdown timer for the automatic irrigation controller.
- On a start request it opens the valve and counts a BCD digit down from START_VAL to 0, one step per prescaled tick.
- Drives the 4-bit digit C3..C0 consumed directly by the display decoder stage, plus valve/status outputs.
- Supports pause, abort and early termination when the soil-wet sensor asserts.

Parameters:
- PRESCALE, 50000000, clock cycles per countdown step (1 s at 50 MHz); legal range 2..2^26.
- START_VAL, 9, initial digit loaded on start; legal range 1..9, elaboration error otherwise.

Ports:
- CLK  input  1  system clock, all state updates on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  synchronous, pre-debounced; sampled every cycle.
- PAUSE  input  1  level; holds countdown while high.
- ABORT  input  1  synchronous; cancels cycle without DONE.
- WET  input  1  synchronous soil-wet sensor level; ends cycle early.
- C3  output  1  digit bit 3 (MSB) to decoder.
- C2  output  1  digit bit 2.
- C1  output  1  digit bit 1.
- C0  output  1  digit bit 0 (LSB).
- VALVE  output  1  valve drive; high only while counting.
- BUSY  output  1  high in RUN or PAUSED.
- DONE  output  1  high in DONE state.

Behaviour:
- Interface: one clock (CLK); reset RST_N is asynchronous, active-low. The reset value of every output is 0: C3..C0=0000, VALVE=0, BUSY=0, DONE=0. State is IDLE and the prescaler is 0.
- All outputs are registered and are a function of state and count only. There is no combinational input-to-output path.
- States: IDLE, RUN, PAUSED, DONE. Per-cycle priority: ABORT > START > WET > PAUSE > tick.
- IDLE: count=0. START=1 -> RUN, count<=START_VAL, prescaler<=0.
- RUN:
  - VALVE=1, BUSY=1.
  - prescaler increments each cycle. tick = (prescaler==PRESCALE-1), and on tick prescaler wraps to 0.
  - On tick with count>1: count<=count-1.
  - On tick with count==1: count<=0, go to DONE.
  - WET=1 -> DONE, count<=0, on the same edge.
  - PAUSE=1 (and no WET/ABORT) -> PAUSED. The prescaler value is retained and no tick is taken that cycle.
- PAUSED:
  - VALVE=0, BUSY=1, count and prescaler frozen.
  - PAUSE=0 -> RUN, resuming from the frozen prescaler value.
  - WET=1 -> DONE, count<=0.
- DONE:
  - count=0, VALVE=0, BUSY=0, DONE=1.
  - Held until START (-> RUN, reload) or ABORT (-> IDLE).
- START in RUN or PAUSED is ignored, with no restart.
- ABORT in any state -> IDLE next edge: count 0, prescaler 0, DONE not asserted.
- Latency:
  - VALVE rises on the edge that samples START.
  - First decrement occurs PRESCALE cycles after that edge.
  - Uninterrupted valve-open time = START_VAL*PRESCALE cycles.
- Digit: plain binary 0..9. Values 10..15 never appear. An assertion flags count>9.
- Reset mid-operation: immediate return to reset values regardless of state. No partial cycle resumes after RST_N deasserts.
- START and ABORT together: ABORT wins, result IDLE.
- START and WET together in IDLE: go to RUN; WET is evaluated from the next cycle, so the cycle ends immediately.

Decomposition:
- Shared package contains:
  - the state encoding constants IDLE=2'd0, RUN=2'd1, PAUSED=2'd2, DONE=2'd3;
  - DIGIT_MAX=9;
  - the prescaler-width function clog2(PRESCALE).
- One natural sub-module: rega_tick_gen, the prescaler.
  - Inputs: CLK, RST_N, EN, CLR.
  - Output: TICK.
  - Counts 0..PRESCALE-1 while EN, frozen while !EN, zeroed on CLR.
- The FSM, digit register and output register stay in rega_countdown.

Test Plan (PRESCALE=4, START_VAL=3):
- Reset: hold RST_N=0 with START=1 -> C3..C0=0000, VALVE=0, BUSY=0, DONE=0 throughout; RST_N released -> IDLE, outputs unchanged.
- Full cycle: 1-cycle START pulse -> C=3 for 4 cycles, then 2 for 4, 1 for 4, then 0 with DONE=1 and VALVE=0; VALVE high exactly 12 cycles.
- Pause: PAUSE high 5 cycles starting 2 cycles into C=2 -> C stays 2, VALVE=0, BUSY=1 while paused; after release C=2 for 2 more cycles; total VALVE-high 12, total cycle 17.
- WET early end: WET=1 while C=2 -> next edge C=0, DONE=1, VALVE=0; then START -> C=3, DONE=0, VALVE=1.
- Abort priority: ABORT during PAUSED -> IDLE, DONE never asserts; START+ABORT same cycle in IDLE -> stays IDLE, VALVE=0.
- Async reset mid-RUN: drop RST_N between clock edges at C=1 -> outputs 0000/VALVE=0 immediately without a clock edge; after release a START runs a full 12-cycle cycle.
